load_store_unit: RTL and testbench

- Services the data-memory side of the control path: takes one load or store per handshake, as flagged by the decoder's mem_read/mem_write plus funct3, and executes it against a word-addressed data-memory port with grant/rvalid handshakes.
- Loads return byte/half/word data, sign- or zero-extended; misaligned or illegal accesses return an error with no memory access.
- Sits between execute (address = rs1 + imm) and writeback.

---
 rtl/lsu_pkg.sv | 71 +++++++
 rtl/load_store_unit_if.sv | 57 +++++
 rtl/load_store_unit_align.sv | 25 ++
 rtl/load_store_unit.sv | 88 ++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types: funct3 codes, access sizes, FSM states,
// latched request bundle and the access-rule helpers.
package lsu_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;
    typedef enum logic {OP_LOAD, OP_STORE} op_e;

    typedef struct packed {
        op_e                       op;
        logic [2:0]                funct3;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [XLEN-1:0]           wdata;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } lsu_req_t;

    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
        if (rd == wr) return 1'b0;
        // unsigned variants exist only for sub-word loads
        if (f3[2] && !rd) return 1'b0;
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return !a[0];
            2'b10:   return (a == 2'b00) && !f3[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input size_e      sz,
                                               input logic [1:0] a);
        case (sz)
            BYTE:    return 4'b0001 << a;
            HALF:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input size_e           sz,
                                                   input logic [XLEN-1:0] d);
        case (sz)
            BYTE:    return {4{d[7:0]}};
            HALF:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and word-addressed data-memory bundle
// for the load/store unit.
interface lsu_core_if;
    import lsu_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_mem_read;
    logic                      req_mem_write;
    logic [2:0]                req_funct3;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [XLEN-1:0]           req_wdata;
    logic [REG_ADDR_WIDTH-1:0] req_rd;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [XLEN-1:0]           resp_rdata;
    logic [REG_ADDR_WIDTH-1:0] resp_rd;
    logic                      resp_is_load;
    logic                      resp_err;

    modport master (
        output req_valid, req_mem_read, req_mem_write, req_funct3,
        output req_addr, req_wdata, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_rd,
        input  resp_is_load, resp_err
    );

    modport slave (
        input  req_valid, req_mem_read, req_mem_write, req_funct3,
        input  req_addr, req_wdata, req_rd, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_rd,
        output resp_is_load, resp_err
    );
endinterface

interface lsu_dmem_if;
    import lsu_pkg::*;

    logic                  dmem_req;
    logic                  dmem_gnt;
    logic                  dmem_we;
    logic [3:0]            dmem_be;
    logic [ADDR_WIDTH-3:0] dmem_addr;
    logic [XLEN-1:0]       dmem_wdata;
    logic                  dmem_rvalid;
    logic [XLEN-1:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Picks the addressed byte/half out of a read word and sign- or
// zero-extends it to XLEN.
module load_align_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);
    logic [XLEN-1:0] w_shift;
    logic            w_sgn;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};
    assign w_sgn   = !i_funct3[2];

    always_comb begin
        o_data = w_shift;
        case (f3_size(i_funct3))
            BYTE:    o_data = {{24{w_shift[7] & w_sgn}}, w_shift[7:0]};
            HALF:    o_data = {{16{w_shift[15] & w_sgn}}, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, runs it on the
// data-memory port and returns an extended load value or an error.
module load_store_unit
    import lsu_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    lsu_core_if.slave   core,
    lsu_dmem_if.master  dmem
);
    state_e          r_state;
    state_e          w_state_next;
    lsu_req_t        r_req;
    logic            r_err;
    logic            r_is_load;
    logic [XLEN-1:0] r_rdata;
    logic            w_legal;
    logic            w_accept;
    size_e           w_size;
    logic [XLEN-1:0] w_load_data;

    assign w_legal = access_legal(core.req_mem_read, core.req_mem_write,
                                  core.req_funct3, core.req_addr[1:0]);
    assign w_accept = (r_state == IDLE) && core.req_valid;
    assign w_size   = f3_size(r_req.funct3);

    load_align_extend u_align (
        .i_rdata   (dmem.dmem_rdata),
        .i_addr_lo (r_req.addr[1:0]),
        .i_funct3  (r_req.funct3),
        .o_data    (w_load_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:
                if (core.req_valid) w_state_next = w_legal ? REQ : RESP;
            REQ:
                if (dmem.dmem_gnt)
                    w_state_next = (r_req.op == OP_STORE) ? RESP : WAIT_R;
            WAIT_R:
                if (dmem.dmem_rvalid) w_state_next = RESP;
            RESP:
                if (core.resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_req     <= '0;
            r_err     <= 1'b0;
            r_is_load <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_req.op     <= core.req_mem_write ? OP_STORE : OP_LOAD;
                r_req.funct3 <= core.req_funct3;
                r_req.addr   <= core.req_addr;
                r_req.wdata  <= core.req_wdata;
                r_req.rd     <= core.req_rd;
                r_err        <= !w_legal;
                r_is_load    <= core.req_mem_read && w_legal;
                r_rdata      <= '0;
            end
            if ((r_state == WAIT_R) && dmem.dmem_rvalid)
                r_rdata <= w_load_data;
        end
    end

    assign core.req_ready    = (r_state == IDLE);
    assign core.resp_valid   = (r_state == RESP);
    assign core.resp_rdata   = r_rdata;
    assign core.resp_rd      = r_req.rd;
    assign core.resp_is_load = r_is_load;
    assign core.resp_err     = r_err;

    // payload is a pure function of the latched request, so it holds until gnt
    assign dmem.dmem_req   = (r_state == REQ);
    assign dmem.dmem_we    = (r_state == REQ) && (r_req.op == OP_STORE);
    assign dmem.dmem_be    = (r_state == REQ) ?
                             byte_enable(w_size, r_req.addr[1:0]) : 4'b0000;
    assign dmem.dmem_addr  = r_req.addr[ADDR_WIDTH-1:2];
    assign dmem.dmem_wdata = lane_wdata(w_size, r_req.wdata);
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model
// of access legality, lane selection, extension and handshake timing.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_core_if core ();
    lsu_dmem_if dmem ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core),
        .dmem  (dmem)
    );

    int n_vec  = 0;
    int n_miss = 0;
    // 0 idle, 1 memory request pending, 2 awaiting read data, 3 response
    int phase  = 0;
    bit chk_en = 0;

    logic [31:0] e_rdata, e_wdata;
    logic [29:0] e_addr;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;
    logic        e_we, e_err, e_is_load;

    bit          lit_ld_en = 0;
    logic [31:0] lit_rdata;
    bit          lit_st_en = 0;
    logic [3:0]  lit_be;
    logic [31:0] lit_wdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit rd, input bit wr,
                                 input logic [2:0] f3, input logic [31:0] a);
        if (rd == wr) return 0;
        if (f3[1:0] == 2'b11) return 0;
        if (f3[2] && (wr || nbytes(f3) == 4)) return 0;
        return (int'(a[1:0]) % nbytes(f3)) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w,
                                             input logic [2:0] f3,
                                             input logic [1:0] off);
        int n;
        logic [31:0] v, mask;
        n = nbytes(f3);
        v = w >> (8 * int'(off));
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] rep_data(input logic [31:0] d,
                                             input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic set_exp(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] tag, input logic [31:0] mword);
        int n;
        n = nbytes(f3);
        e_err     = !legal(rd, wr, f3, addr);
        e_we      = wr;
        e_be      = 4'(((1 << n) - 1) << int'(addr[1:0]));
        e_addr    = addr[31:2];
        e_wdata   = rep_data(wd, n);
        e_rd      = tag;
        e_is_load = rd && !e_err;
        e_rdata   = e_is_load ? load_val(mword, f3, addr[1:0]) : 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] tag);
        core.req_valid     = 1'b1;
        core.req_mem_read  = rd;
        core.req_mem_write = wr;
        core.req_funct3    = f3;
        core.req_addr      = addr;
        core.req_wdata     = wd;
        core.req_rd        = tag;
        tick();
        core.req_valid     = 1'b0;
        core.req_mem_read  = 1'($urandom);
        core.req_mem_write = 1'($urandom);
        core.req_funct3    = 3'($urandom);
        core.req_addr      = $urandom;
        core.req_wdata     = $urandom;
        core.req_rd        = 5'($urandom);
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] tag, input logic [31:0] mword,
                          input int gd, input int rvd, input int rsd);
        set_exp(rd, wr, f3, addr, wd, tag, mword);
        issue(rd, wr, f3, addr, wd, tag);
        if (e_err) begin
            phase = 3;
        end else begin
            phase = 1;
            repeat (gd) tick();
            dmem.dmem_gnt = 1'b1;
            tick();
            dmem.dmem_gnt = 1'b0;
            if (!rd) begin
                phase = 3;
            end else begin
                phase = 2;
                repeat (rvd) begin
                    dmem.dmem_rdata = $urandom;
                    tick();
                end
                dmem.dmem_rvalid = 1'b1;
                dmem.dmem_rdata  = mword;
                tick();
                dmem.dmem_rvalid = 1'b0;
                dmem.dmem_rdata  = $urandom;
                phase = 3;
            end
        end
        repeat (rsd) tick();
        core.resp_ready = 1'b1;
        tick();
        core.resp_ready = 1'b0;
        phase = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", core.req_ready, phase == 0);
            chk("dmem_req", dmem.dmem_req, phase == 1);
            chk("resp_valid", core.resp_valid, phase == 3);
            if (phase == 1) begin
                chk("dmem_we", dmem.dmem_we, e_we);
                chk("dmem_be", dmem.dmem_be, e_be);
                chk("dmem_addr", dmem.dmem_addr, e_addr);
                if (e_we) chk("dmem_wdata", dmem.dmem_wdata, e_wdata);
                if (lit_st_en) begin
                    chk("lit_be", dmem.dmem_be, lit_be);
                    chk("lit_wdata", dmem.dmem_wdata, lit_wdata);
                end
            end
            if (phase == 3) begin
                chk("resp_rdata", core.resp_rdata, e_rdata);
                chk("resp_rd", core.resp_rd, e_rd);
                chk("resp_is_load", core.resp_is_load, e_is_load);
                chk("resp_err", core.resp_err, e_err);
                if (lit_ld_en) chk("lit_rdata", core.resp_rdata, lit_rdata);
            end
        end
    end

    task automatic check_idle_regs(input string tag);
        chk({tag, "_req_ready"}, core.req_ready, 1);
        chk({tag, "_resp_valid"}, core.resp_valid, 0);
        chk({tag, "_dmem_req"}, dmem.dmem_req, 0);
        chk({tag, "_dmem_we"}, dmem.dmem_we, 0);
        chk({tag, "_dmem_be"}, dmem.dmem_be, 0);
        chk({tag, "_resp_rdata"}, core.resp_rdata, 0);
        chk({tag, "_resp_rd"}, core.resp_rd, 0);
        chk({tag, "_resp_err"}, core.resp_err, 0);
        chk({tag, "_resp_is_load"}, core.resp_is_load, 0);
    endtask

    initial begin
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind;

        core.req_valid = 0;  core.req_mem_read = 0; core.req_mem_write = 0;
        core.req_funct3 = 0; core.req_addr = 0;     core.req_wdata = 0;
        core.req_rd = 0;     core.resp_ready = 0;
        dmem.dmem_gnt = 0;   dmem.dmem_rvalid = 1;  dmem.dmem_rdata = 32'hDEAD_BEEF;

        // stale rvalid held through and after reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_idle_regs("rst");
        chk_en = 1;
        repeat (3) tick();
        dmem.dmem_rvalid = 0;

        lit_ld_en = 1;
        lit_rdata = 32'hFFFF_FF80;
        run_op(1, 0, LB, 32'h1003, 0, 5'd7, 32'h80FF_1234, 0, 0, 0);
        lit_rdata = 32'h0000_BEEF;
        run_op(1, 0, LHU, 32'h2002, 0, 5'd9, 32'hBEEF_0000, 1, 2, 0);
        lit_rdata = 32'hFFFF_BEEF;
        run_op(1, 0, LH, 32'h2002, 0, 5'd10, 32'hBEEF_0000, 0, 0, 3);
        lit_ld_en = 0;

        lit_st_en = 1;
        lit_be    = 4'b0010;
        lit_wdata = 32'hABAB_ABAB;
        run_op(0, 1, SB, 32'h0001, 32'h0000_00AB, 5'd3, 0, 4, 0, 0);
        lit_st_en = 0;

        run_op(1, 0, LW, 32'h1002, 0, 5'd1, 0, 0, 0, 0);
        run_op(0, 1, SH, 32'h0001, 32'h1234, 5'd2, 0, 0, 0, 1);
        run_op(1, 0, 3'b011, 32'h0000, 0, 5'd4, 0, 0, 0, 0);
        run_op(1, 1, LW, 32'h0040, 0, 5'd5, 0, 0, 0, 0);

        dmem.dmem_rvalid = 1;
        dmem.dmem_rdata  = 32'h1111_2222;
        repeat (3) tick();
        dmem.dmem_rvalid = 0;

        set_exp(1, 0, LW, 32'h0100, 0, 5'd12, 0);
        issue(1, 0, LW, 32'h0100, 0, 5'd12);
        phase = 1;
        dmem.dmem_gnt = 1;
        tick();
        dmem.dmem_gnt = 0;
        phase = 2;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        phase = 0;
        check_idle_regs("wr_rst");
        dmem.dmem_rvalid = 1;
        dmem.dmem_rdata  = 32'h5555_AAAA;
        repeat (2) tick();
        dmem.dmem_rvalid = 0;
        run_op(1, 0, LW, 32'h0104, 0, 5'd13, 32'hCAFE_F00D, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 7));
            rd = (kind == 0) || (kind >= 2 && kind < 5);
            wr = (kind == 0) || (kind >= 5);
            f3 = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0) begin
                dmem.dmem_rvalid = 1;
                dmem.dmem_rdata  = $urandom;
                tick();
                dmem.dmem_rvalid = 0;
            end
            run_op(rd, wr, f3, addr, $urandom, 5'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
